// File: rtl/exc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Module : exc_pkg
// Brief  : Shared types and encodings for the exception/interrupt sequencer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_LEAVE   = 2'd3
  } exc_state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
  localparam logic [1:0] PC_SEL_HANDLER = 2'd1;
  localparam logic [1:0] PC_SEL_EPC     = 2'd2;

  // Width of an interrupt line index; never zero so a single line still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_if.sv
// ----------------------------------------------------------------------------
// Module : exc_ctrl_if
// Brief  : Pipeline/CP0 side signal bundle of the exception sequencer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface exc_ctrl_if #(
  parameter int NIRQ = 6,
  parameter int PCW  = 32
) ();

  logic [PCW-1:0]  pc_i;
  logic            exc_ri_i;
  logic            exc_ov_i;
  logic            exc_sys_i;
  logic [NIRQ-1:0] irq_i;
  logic            mask_we_i;
  logic [NIRQ-1:0] mask_wdata_i;
  logic            eret_i;

  logic            exl_set_o;
  logic            exl_clear_o;
  logic [PCW-1:0]  epc_o;
  logic [4:0]      exc_code_o;
  logic            flush_o;
  logic [1:0]      pc_sel_o;
  logic            in_handler_o;
  logic [NIRQ-1:0] irq_pending_o;
  logic            double_fault_o;

  modport master (
    output pc_i, exc_ri_i, exc_ov_i, exc_sys_i, irq_i,
           mask_we_i, mask_wdata_i, eret_i,
    input  exl_set_o, exl_clear_o, epc_o, exc_code_o, flush_o,
           pc_sel_o, in_handler_o, irq_pending_o, double_fault_o
  );

  modport slave (
    input  pc_i, exc_ri_i, exc_ov_i, exc_sys_i, irq_i,
           mask_we_i, mask_wdata_i, eret_i,
    output exl_set_o, exl_clear_o, epc_o, exc_code_o, flush_o,
           pc_sel_o, in_handler_o, irq_pending_o, double_fault_o
  );

endinterface

`default_nettype wire

// File: rtl/exc_ctrl_prio_enc.sv
// ----------------------------------------------------------------------------
// Module : exc_prio_enc
// Brief  : Combinational cause arbiter: ri > ov > sys > lowest-index irq.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NIRQ = 6,
  parameter int IW   = idx_width(NIRQ)
) (
  input  logic            ri_i,
  input  logic            ov_i,
  input  logic            sys_i,
  input  logic [NIRQ-1:0] irq_i,
  output logic            valid_o,
  output logic [4:0]      code_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    idx_o = '0;
    // Walk downwards so the lowest asserted line is the last one written.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_i[i]) idx_o = IW'(i);
    end

    valid_o = ri_i | ov_i | sys_i | (|irq_i);

    if (ri_i)       code_o = EXC_RI;
    else if (ov_i)  code_o = EXC_OV;
    else if (sys_i) code_o = EXC_SYS;
    else            code_o = EXC_INT;
  end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// Module : exc_ctrl
// Brief  : Exception/interrupt sequencer driving CP0 EXL strobes, EPC, flush
//          and fetch steering. EXC_CTRL_IRQ_EDGE_EN selects edge-triggered
//          interrupt pending instead of level-sensitive.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module exc_ctrl
  import exc_pkg::*;
#(
  parameter int NIRQ = 6,
  parameter int PCW  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  exc_ctrl_if.slave  bus
);

  localparam int IW = idx_width(NIRQ);

  exc_state_t      state_q, state_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic            dwell_q, dwell_d;
  logic [4:0]      code_q, code_d;
  logic [PCW-1:0]  epc_q, epc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            exl_set_q, exl_set_d;
  logic            exl_clear_q, exl_clear_d;
  logic            flush_q, flush_d;
  logic [1:0]      pc_sel_q, pc_sel_d;
  logic            in_handler_q, in_handler_d;
  logic            dfault_q, dfault_d;

  logic            w_sync;
  logic [NIRQ-1:0] w_irq_cand;
  logic [NIRQ-1:0] w_irq_set;
  logic [NIRQ-1:0] w_irq_clr;
  logic            w_valid;
  logic [4:0]      w_code;
  logic [IW-1:0]   w_idx;

  assign w_sync = bus.exc_ri_i | bus.exc_ov_i | bus.exc_sys_i;

  // Interrupts wait one full RUN cycle after eret so the return target commits.
  assign w_irq_cand = pending_q & mask_q & {NIRQ{dwell_q}};

`ifdef EXC_CTRL_IRQ_EDGE_EN
  logic [NIRQ-1:0] irq_q, irq_d;
  assign irq_d     = bus.irq_i;
  assign w_irq_set = bus.irq_i & ~irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_d;
  end
`else
  assign w_irq_set = bus.irq_i;
`endif

  assign w_irq_clr = (state_q == ST_ENTER && code_q == EXC_INT)
                   ? (NIRQ'(1) << idx_q) : '0;

  exc_prio_enc #(
    .NIRQ (NIRQ),
    .IW   (IW)
  ) u_prio (
    .ri_i    (bus.exc_ri_i),
    .ov_i    (bus.exc_ov_i),
    .sys_i   (bus.exc_sys_i),
    .irq_i   (w_irq_cand),
    .valid_o (w_valid),
    .code_o  (w_code),
    .idx_o   (w_idx)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    epc_d     = epc_q;
    idx_d     = idx_q;
    dfault_d  = dfault_q;
    pending_d = (pending_q & ~w_irq_clr) | w_irq_set;
    mask_d    = bus.mask_we_i ? bus.mask_wdata_i : mask_q;
    dwell_d   = (state_q == ST_RUN);

    case (state_q)
      ST_RUN: begin
        if (w_valid) begin
          state_d = ST_ENTER;
          code_d  = w_code;
          epc_d   = bus.pc_i;
          idx_d   = w_idx;
        end
      end
      ST_ENTER: state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (w_sync)     dfault_d = 1'b1;
        if (bus.eret_i) state_d  = ST_LEAVE;
      end
      ST_LEAVE: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // Outputs are registered from the next state so they align with it.
    exl_set_d    = (state_d == ST_ENTER);
    exl_clear_d  = (state_d == ST_LEAVE);
    flush_d      = (state_d == ST_ENTER) || (state_d == ST_LEAVE);
    in_handler_d = (state_d == ST_HANDLER) || (state_d == ST_LEAVE);
    if (state_d == ST_ENTER)      pc_sel_d = PC_SEL_HANDLER;
    else if (state_d == ST_LEAVE) pc_sel_d = PC_SEL_EPC;
    else                          pc_sel_d = PC_SEL_SEQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pending_q    <= '0;
      mask_q       <= '0;
      dwell_q      <= 1'b0;
      code_q       <= '0;
      epc_q        <= '0;
      idx_q        <= '0;
      exl_set_q    <= 1'b0;
      exl_clear_q  <= 1'b0;
      flush_q      <= 1'b0;
      pc_sel_q     <= PC_SEL_SEQ;
      in_handler_q <= 1'b0;
      dfault_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      code_q       <= code_d;
      epc_q        <= epc_d;
      idx_q        <= idx_d;
      exl_set_q    <= exl_set_d;
      exl_clear_q  <= exl_clear_d;
      flush_q      <= flush_d;
      pc_sel_q     <= pc_sel_d;
      in_handler_q <= in_handler_d;
      dfault_q     <= dfault_d;
    end
  end

  assign bus.exl_set_o      = exl_set_q;
  assign bus.exl_clear_o    = exl_clear_q;
  assign bus.epc_o          = epc_q;
  assign bus.exc_code_o     = code_q;
  assign bus.flush_o        = flush_q;
  assign bus.pc_sel_o       = pc_sel_q;
  assign bus.in_handler_o   = in_handler_q;
  assign bus.irq_pending_o  = pending_q;
  assign bus.double_fault_o = dfault_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ----------------------------------------------------------------------------
// Module : tb_exc_ctrl
// Brief  : Scoreboard bench for exc_ctrl; EXC_CTRL_IRQ_EDGE_EN selects the
//          edge-mode expectations of the held-line scenario.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exc_ctrl;
  import exc_pkg::*;

  localparam int NIRQ = 6;
  localparam int PCW  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exc_ctrl_if #(.NIRQ(NIRQ), .PCW(PCW)) bus ();

  exc_ctrl #(.NIRQ(NIRQ), .PCW(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit             is_set;
    logic [4:0]     code;
    logic [PCW-1:0] epc;
    int             at;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic expect_set(input logic [4:0] c, input logic [PCW-1:0] pc, input int at);
    exp_t e;
    e.is_set = 1'b1; e.code = c; e.epc = pc; e.at = at;
    sb.push_back(e);
  endtask

  task automatic expect_clr(input int at);
    exp_t e;
    e.is_set = 1'b0; e.code = '0; e.epc = '0; e.at = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  // Monitor: every EXL strobe must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (bus.exl_set_o || bus.exl_clear_o)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_strobe: set=%0b clr=%0b at cycle %0d, none queued",
                 bus.exl_set_o, bus.exl_clear_o, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(e.at));
        check("strobe_kind", 64'({bus.exl_set_o, bus.exl_clear_o}),
              64'(e.is_set ? 2'b10 : 2'b01));
        check("strobe_flush", 64'(bus.flush_o), 64'(1'b1));
        check("strobe_pc_sel", 64'(bus.pc_sel_o),
              64'(e.is_set ? PC_SEL_HANDLER : PC_SEL_EPC));
        if (e.is_set) begin
          check("entry_code", 64'(bus.exc_code_o), 64'(e.code));
          check("entry_epc", 64'(bus.epc_o), 64'(e.epc));
          check("entry_in_handler", 64'(bus.in_handler_o), 64'(1'b0));
        end else begin
          check("leave_in_handler", 64'(bus.in_handler_o), 64'(1'b1));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a, m, w;
    bus.pc_i = '0; bus.exc_ri_i = 1'b0; bus.exc_ov_i = 1'b0; bus.exc_sys_i = 1'b0;
    bus.irq_i = '0; bus.mask_we_i = 1'b0; bus.mask_wdata_i = '0; bus.eret_i = 1'b0;

    tick(); tick();
    check("rst_ctrl", 64'({bus.exl_set_o, bus.exl_clear_o, bus.flush_o, bus.pc_sel_o,
                           bus.in_handler_o, bus.double_fault_o}), 64'(0));
    check("rst_epc", 64'(bus.epc_o), 64'(0));
    check("rst_code", 64'(bus.exc_code_o), 64'(0));
    check("rst_pending", 64'(bus.irq_pending_o), 64'(0));
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Syscall in RUN
    bus.pc_i = 32'h40; bus.exc_sys_i = 1'b1;
    expect_set(EXC_SYS, 32'h40, cyc + 1);
    tick(); bus.exc_sys_i = 1'b0;
    tick();
    check("t1_in_handler", 64'(bus.in_handler_o), 64'(1'b1));
    bus.eret_i = 1'b1; expect_clr(cyc + 1);
    tick(); bus.eret_i = 1'b0;
    tick(); tick();

    // ri and ov together: ri wins, single entry
    bus.pc_i = 32'h100; bus.exc_ri_i = 1'b1; bus.exc_ov_i = 1'b1;
    expect_set(EXC_RI, 32'h100, cyc + 1);
    tick(); bus.exc_ri_i = 1'b0; bus.exc_ov_i = 1'b0;
    tick();
    bus.eret_i = 1'b1; expect_clr(cyc + 1);
    tick(); bus.eret_i = 1'b0;
    tick(); tick();

    // Interrupt entry, deferred interrupt in handler, re-entry 3 cycles after clear
    bus.pc_i = 32'h200; bus.mask_we_i = 1'b1; bus.mask_wdata_i = 6'h03; bus.irq_i = 6'h02;
    a = cyc;
    expect_set(EXC_INT, 32'h200, a + 2);
    tick(); bus.mask_we_i = 1'b0; bus.irq_i = '0;
    tick(); tick();
    check("t3_pend_cleared", 64'(bus.irq_pending_o), 64'(0));
    bus.irq_i = 6'h01;
    tick(); bus.irq_i = '0;
    check("t3_pend_held", 64'(bus.irq_pending_o), 64'(6'h01));
    tick();
    bus.pc_i = 32'h300; bus.eret_i = 1'b1; m = cyc;
    expect_clr(m + 1);
    expect_set(EXC_INT, 32'h300, m + 4);
    tick(); bus.eret_i = 1'b0;
    goto(m + 5);
    check("t3_pend_taken", 64'(bus.irq_pending_o), 64'(0));
    bus.eret_i = 1'b1; expect_clr(cyc + 1);
    tick(); bus.eret_i = 1'b0;
    tick(); tick();

    // Double fault in handler, then sync exception coinciding with eret
    bus.pc_i = 32'h500; bus.exc_sys_i = 1'b1;
    expect_set(EXC_SYS, 32'h500, cyc + 1);
    tick(); bus.exc_sys_i = 1'b0;
    tick();
    check("t4_dfault_before", 64'(bus.double_fault_o), 64'(1'b0));
    bus.exc_sys_i = 1'b1;
    tick(); bus.exc_sys_i = 1'b0;
    check("t4_dfault_set", 64'(bus.double_fault_o), 64'(1'b1));
    bus.exc_ov_i = 1'b1; bus.eret_i = 1'b1; expect_clr(cyc + 1);
    tick(); bus.exc_ov_i = 1'b0; bus.eret_i = 1'b0;
    tick();
    check("t4_dfault_sticky", 64'(bus.double_fault_o), 64'(1'b1));
    tick();

    // Masked interrupt pends without entry; unmasking takes it
    bus.mask_we_i = 1'b1; bus.mask_wdata_i = 6'h00;
    tick(); bus.mask_we_i = 1'b0; bus.irq_i = 6'h09;
    tick(); bus.irq_i = '0;
    tick(); tick();
    check("t5_pend_masked", 64'(bus.irq_pending_o), 64'(6'h09));
    bus.pc_i = 32'h700; bus.mask_we_i = 1'b1; bus.mask_wdata_i = 6'h01; w = cyc;
    expect_set(EXC_INT, 32'h700, w + 2);
    tick(); bus.mask_we_i = 1'b0;
    tick(); tick();
    check("t5_pend_after", 64'(bus.irq_pending_o), 64'(6'h08));
    bus.eret_i = 1'b1; expect_clr(cyc + 1);
    tick(); bus.eret_i = 1'b0;
    tick(); tick();

    // Reset asserted in the middle of ENTER
    bus.pc_i = 32'h800; bus.exc_sys_i = 1'b1;
    tick(); bus.exc_sys_i = 1'b0;
    check("t6_enter_seen", 64'(bus.exl_set_o), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", 64'({bus.exl_set_o, bus.exl_clear_o, bus.flush_o, bus.pc_sel_o,
                              bus.in_handler_o, bus.double_fault_o}), 64'(0));
    check("t6_rst_pending", 64'(bus.irq_pending_o), 64'(0));
    check("t6_rst_epc", 64'(bus.epc_o), 64'(0));
    tick(); rst_n = 1'b1;
    tick(); tick(); tick();

    // Line 2 held high for 10 cycles
    bus.pc_i = 32'h600; bus.mask_we_i = 1'b1; bus.mask_wdata_i = 6'h04; w = cyc;
    tick(); bus.mask_we_i = 1'b0; bus.irq_i = 6'h04;
    expect_set(EXC_INT, 32'h600, w + 3);
    expect_clr(w + 6);
`ifndef EXC_CTRL_IRQ_EDGE_EN
    expect_set(EXC_INT, 32'h600, w + 9);
    expect_clr(w + 12);
    expect_set(EXC_INT, 32'h600, w + 15);
    expect_clr(w + 18);
`endif
    goto(w + 5);  bus.eret_i = 1'b1;
    tick();       bus.eret_i = 1'b0;
    goto(w + 11); bus.irq_i = '0; bus.eret_i = 1'b1;
    tick();       bus.eret_i = 1'b0;
    goto(w + 17); bus.eret_i = 1'b1;
    tick();       bus.eret_i = 1'b0;
    goto(w + 21);
    check("t7_pending_idle", 64'(bus.irq_pending_o), 64'(0));

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer in front of the CP0 register block.
- Arbitrates synchronous exceptions (reserved instruction, overflow, syscall) and NIRQ hardware interrupt lines.
- Drives the CP0 EXL set/clear strobes and the faulting PC, flushes the pipeline, and steers the fetch PC to the handler or back to EPC.
- Sits between the commit/execute stage and CP0. Allows one level of exception; no nesting.

Parameters:
- NIRQ, 6, number of hardware interrupt lines
- PCW, 32, PC width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_i  in  PCW  PC of instruction currently committing
- exc_ri_i  in  1  reserved-instruction exception
- exc_ov_i  in  1  arithmetic overflow exception
- exc_sys_i  in  1  syscall exception
- irq_i  in  NIRQ  hardware interrupt lines
- mask_we_i  in  1  write enable for the interrupt mask
- mask_wdata_i  in  NIRQ  new interrupt mask; 1 = enabled
- eret_i  in  1  eret committing
- exl_set_o  out  1  one-cycle strobe to CP0 EXLSet
- exl_clear_o  out  1  one-cycle strobe to CP0 EXLClear
- epc_o  out  PCW  PC to store in CP0 EPC; valid with exl_set_o
- exc_code_o  out  5  cause code of the exception being taken
- flush_o  out  1  flush IF/ID/EX
- pc_sel_o  out  2  fetch select: 0 = sequential, 1 = handler_PC, 2 = EPC
- in_handler_o  out  1  handler active (EXL = 1)
- irq_pending_o  out  NIRQ  pending interrupt bits
- double_fault_o  out  1  sticky: sync exception raised inside handler

Behaviour:
- States: RUN, ENTER, HANDLER, LEAVE. Reset (async, rst_n = 0) forces:
  - state = RUN
  - all outputs 0, epc_o = 0, exc_code_o = 0
  - pending = 0, mask = 0
  - double_fault_o = 0
  - RUN-dwell flag = 0
- Pending: each cycle pending[i] |= irq_i[i]. Bit i clears only in the ENTER cycle of an interrupt taken on line i. If set and clear coincide, set wins.
- Mask: written on mask_we_i at the clock edge; it affects arbitration from the next cycle.
- RUN:
  - Priority: ri > ov > sys > (pending & mask) lowest index.
  - Codes: ri = 10, ov = 12, sys = 8, interrupt = 0.
  - Any candidate: latch the code, latch pc_i into EPC, latch the winning irq index; go to ENTER.
  - Interrupts are arbitrated only when the RUN-dwell flag is 1. The flag sets after one full cycle in RUN, which guarantees forward progress after eret. Sync exceptions ignore the flag.
  - eret_i in RUN is ignored.
  - A lower-priority simultaneous request remains pending or must be re-raised by the pipeline.
- ENTER (exactly 1 cycle):
  - exl_set_o = 1, flush_o = 1, pc_sel_o = 1.
  - epc_o and exc_code_o hold the latched values.
  - Clear the pending bit if the cause was an interrupt.
  - Next state HANDLER.
- HANDLER:
  - in_handler_o = 1; interrupts accumulate in pending but are not taken.
  - A sync exception sets double_fault_o (sticky until reset) and is otherwise ignored: no exl_set_o, no flush.
  - eret_i: go to LEAVE. eret takes priority over a same-cycle sync exception; double_fault_o is still set.
- LEAVE (exactly 1 cycle):
  - exl_clear_o = 1, flush_o = 1, pc_sel_o = 2, in_handler_o = 1.
  - Next state RUN with the dwell flag cleared.
- Latency: request in cycle N gives exl_set_o in cycle N+1. eret in cycle M gives exl_clear_o in cycle M+1 and earliest interrupt exl_set_o in cycle M+4.
- exl_set_o and exl_clear_o are never asserted in the same cycle.
- A reset mid-ENTER or mid-LEAVE aborts immediately; no partial strobe survives.

Optional Feature:
- Macro EXC_CTRL_IRQ_EDGE_EN.
- Defined: pending[i] sets only on a rising edge of irq_i[i], using a registered copy reset to 0. A held-high line is taken once.
- Undefined: level-sensitive as above; a held-high line re-pends after being cleared.

Decomposition:
- Package exc_pkg holds:
  - state enum
  - cause-code constants: EXC_INT = 0, EXC_SYS = 8, EXC_RI = 10, EXC_OV = 12
  - PC_SEL_SEQ / PC_SEL_HANDLER / PC_SEL_EPC encodings
- One sub-module exc_prio_enc: combinational priority encoder taking sync flags and masked pending, producing valid, code and irq index.

Test Plan:
- Syscall in RUN: exc_sys_i = 1 at pc_i = 0x40 → next cycle exl_set_o = 1, epc_o = 0x40, exc_code_o = 8, flush_o = 1, pc_sel_o = 1; then in_handler_o = 1.
- Simultaneous exc_ov_i and exc_ri_i with pc_i = 0x100 → exc_code_o = 10, epc_o = 0x100; only one exl_set_o pulse.
- Mask write 0x03, irq_i = 0x02 → ENTER with code 0, pending[1] cleared. Interrupt raised while in HANDLER is not taken; after eret, exl_clear_o and pc_sel_o = 2 pulse, and the interrupt is taken exactly 3 cycles after exl_clear_o.
- Syscall while in HANDLER → double_fault_o = 1 (sticky), no exl_set_o. eret the same cycle → LEAVE still occurs.
- irq_i[0] = 1 with mask = 0 → pending[0] = 1, no entry. A later mask write of 0x01 → entry one cycle after the write.
- rst_n low during ENTER → all outputs 0 immediately, pending = 0. With EXC_CTRL_IRQ_EDGE_EN defined, irq_i[2] held high for 10 cycles gives exactly one entry.
